// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
package ccff_chain_loader_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StClear = 2'd1,
      StLoad  = 2'd2,
      StDone  = 2'd3
   } state_e;

   // Width of a counter able to hold the values 0..n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer and MSB-first serialiser feeding the chain data input.
// Outputs are registered; the first bit of an accepted word is presented
// on the cycle right after the handshake.
module ccff_word_serializer
   import ccff_chain_loader_pkg::*;
#(
   parameter int unsigned WORD_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load_en,     // parent is in LOAD and still needs bits
   input  logic              i_ready_allow, // next cycle is LOAD with bits still missing
   input  logic [WORD_W-1:0] i_word_in,
   input  logic              i_word_valid,
   output logic              o_word_ready,
   output logic              o_chain_d,
   output logic              o_chain_we,
   output logic              o_step         // a bit is presented from the next cycle on
);

   localparam int unsigned LeftW = cnt_width(WORD_W);

   logic [WORD_W-1:0] r_sh;
   logic [WORD_W-1:0] w_sh_d;
   logic [LeftW-1:0]  r_left;   // buffered bits not yet presented on chain_d
   logic [LeftW-1:0]  w_left_d;
   logic              r_ready;
   logic              w_ready_d;
   logic              r_chain_d;
   logic              w_chain_d_d;
   logic              r_chain_we;
   logic              w_accept;
   logic              w_step;

   // Handshake, shift and next-ready computation.
   always_comb begin
      w_accept    = i_load_en && r_ready && i_word_valid && (r_left == '0);
      w_step      = i_load_en && ((r_left != '0) || w_accept);
      w_sh_d      = r_sh;
      w_left_d    = r_left;
      w_chain_d_d = r_chain_d;
      if (!i_load_en) begin
         // Leaving LOAD (done, abort, or never entered): drop any buffered bits.
         w_left_d = '0;
      end else if (w_accept) begin
         w_chain_d_d = i_word_in[WORD_W-1];
         w_sh_d      = i_word_in << 1;
         w_left_d    = LeftW'(WORD_W - 1);
      end else if (w_step) begin
         w_chain_d_d = r_sh[WORD_W-1];
         w_sh_d      = r_sh << 1;
         w_left_d    = r_left - LeftW'(1);
      end
      // Ready while the last buffered bit goes out keeps the stream gap-free.
      w_ready_d = i_ready_allow && (w_left_d == '0);
   end

   // Serialiser state and registered chain-side outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sh       <= '0;
         r_left     <= '0;
         r_ready    <= 1'b0;
         r_chain_d  <= 1'b0;
         r_chain_we <= 1'b0;
      end else begin
         r_sh       <= w_sh_d;
         r_left     <= w_left_d;
         r_ready    <= w_ready_d;
         r_chain_d  <= w_chain_d_d;
         r_chain_we <= w_step;
      end
   end

   assign o_word_ready = r_ready;
   assign o_chain_d    = r_chain_d;
   assign o_chain_we   = r_chain_we;
   assign o_step       = w_step;

endmodule

// File: rtl/ccff_chain_loader.sv
// Sequencing controller for a write-enable flip-flop configuration chain:
// clears the chain, streams words MSB-first onto it, reports completion.
module ccff_chain_loader
   import ccff_chain_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN  = 64,
   parameter int unsigned WORD_W     = 8,
   parameter int unsigned CLR_CYCLES = 2
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_start,
   input  logic                              i_abort,
   input  logic [WORD_W-1:0]                 i_word_in,
   input  logic                              i_word_valid,
   output logic                              o_word_ready,
   output logic                              o_chain_d,
   output logic                              o_chain_we,
   output logic                              o_chain_rst,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [cnt_width(CHAIN_LEN)-1:0]   o_bits_loaded
);

   localparam int unsigned     CntW    = cnt_width(CHAIN_LEN);
   localparam int unsigned     ClrW    = idx_width(CLR_CYCLES);
   localparam logic [CntW-1:0] LenCnt  = CntW'(CHAIN_LEN);
   localparam logic [ClrW-1:0] ClrLast = ClrW'(CLR_CYCLES - 1);

   state_e          r_state;
   state_e          w_state_d;
   logic [ClrW-1:0] r_clr_cnt;
   logic [ClrW-1:0] w_clr_cnt_d;
   logic [CntW-1:0] r_bits;
   logic [CntW-1:0] w_bits_d;
   logic            r_chain_rst;
   logic            r_busy;
   logic            r_done;
   logic            w_last;
   logic            w_load_en;
   logic            w_ready_allow;
   logic            w_step;

   // All CHAIN_LEN bits have been presented; nothing more may go out.
   assign w_last    = (r_bits == LenCnt);
   assign w_load_en = (r_state == StLoad) && !i_abort && !w_last;

   // Next state and counters; abort outranks everything outside IDLE.
   always_comb begin
      w_state_d   = r_state;
      w_clr_cnt_d = r_clr_cnt;
      w_bits_d    = r_bits;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_d   = StClear;
               w_clr_cnt_d = '0;
               w_bits_d    = '0;
            end
         end
         StClear: begin
            if (i_abort) begin
               w_state_d = StIdle;
            end else if (r_clr_cnt == ClrLast) begin
               w_state_d = StLoad;
            end else begin
               w_clr_cnt_d = r_clr_cnt + ClrW'(1);
            end
         end
         StLoad: begin
            if (i_abort) begin
               w_state_d = StIdle;
            end else if (w_last) begin
               w_state_d = StDone;
            end else if (w_step) begin
               w_bits_d = r_bits + CntW'(1);
            end
         end
         StDone: begin
            if (i_abort) begin
               w_state_d = StIdle;
            end else if (i_start) begin
               w_state_d   = StClear;
               w_clr_cnt_d = '0;
               w_bits_d    = '0;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Ready is only offered when the next cycle is LOAD and bits are still missing.
   assign w_ready_allow = (w_state_d == StLoad) && (w_bits_d != LenCnt);

   ccff_word_serializer #(
      .WORD_W (WORD_W)
   ) u_serializer (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_load_en     (w_load_en),
      .i_ready_allow (w_ready_allow),
      .i_word_in     (i_word_in),
      .i_word_valid  (i_word_valid),
      .o_word_ready  (o_word_ready),
      .o_chain_d     (o_chain_d),
      .o_chain_we    (o_chain_we),
      .o_step        (w_step)
   );

   // FSM state, counters and registered status outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_clr_cnt   <= '0;
         r_bits      <= '0;
         r_chain_rst <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_clr_cnt   <= w_clr_cnt_d;
         r_bits      <= w_bits_d;
         r_chain_rst <= (w_state_d == StClear);
         r_busy      <= (w_state_d == StClear) || (w_state_d == StLoad);
         r_done      <= (w_state_d == StDone);
      end
   end

   assign o_chain_rst   = r_chain_rst;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_bits_loaded = r_bits;

endmodule
